// File: rtl/conv1d_seq_ctrl_pkg.sv
// Shared definitions for the conv1d sequencer: data width and FSM state encoding.
package conv1d_seq_ctrl_pkg;

    localparam int unsigned WIDTH_DATA = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        COMMIT = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/conv1d_seq_ctrl_if.sv
// Job, weight-stream, sample-stream and conv1d-facing signals of the sequencer.
interface conv1d_seq_ctrl_if #(
    parameter int unsigned K     = 15,
    parameter int unsigned LEN_W = 16
) ();
    import conv1d_seq_ctrl_pkg::*;

    localparam int unsigned W = WIDTH_DATA;

    logic             start;
    logic [LEN_W-1:0] seq_len;
    logic             busy;
    logic             done;
    logic             w_valid;
    logic [W-1:0]     w_data;
    logic             w_ready;
    logic             x_valid;
    logic [W-1:0]     x_data;
    logic             x_ready;
    logic             conv_w_en;
    logic [K*W-1:0]   conv_w;
    logic [K*W-1:0]   conv_din;
    logic             conv_din_valid;
    logic [LEN_W-1:0] win_cnt;

    modport master (
        output start, seq_len, w_valid, w_data, x_valid, x_data,
        input  busy, done, w_ready, x_ready, conv_w_en, conv_w,
               conv_din, conv_din_valid, win_cnt
    );

    modport slave (
        input  start, seq_len, w_valid, w_data, x_valid, x_data,
        output busy, done, w_ready, x_ready, conv_w_en, conv_w,
               conv_din, conv_din_valid, win_cnt
    );

endinterface

// File: rtl/conv1d_win_buf.sv
// K-deep sample shift register; slot K-1 holds the newest sample, slot 0 the oldest.
module conv1d_win_buf #(
    parameter int unsigned K = 15,
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clear,
    input  logic           i_shift,
    input  logic [W-1:0]   i_din,
    output logic [K*W-1:0] o_win
);

    logic [K*W-1:0] r_win;

    generate
        if (K > 1) begin : g_deep
            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_win <= '0;
                end else if (i_shift) begin
                    r_win <= {i_din, r_win[K*W-1:W]};
                end
            end
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_win <= '0;
                end else if (i_shift) begin
                    r_win <= i_din;
                end
            end
        end
    endgenerate

    assign o_win = r_win;

endmodule

// File: rtl/conv1d_seq_ctrl.sv
// Job sequencer for conv1d: loads and commits K weights, then streams stride-S sample windows.
module conv1d_seq_ctrl
    import conv1d_seq_ctrl_pkg::*;
#(
    parameter int unsigned K     = 15,
    parameter int unsigned S     = 1,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    conv1d_seq_ctrl_if.slave bus
);

    localparam int unsigned W     = WIDTH_DATA;
    localparam int unsigned PTR_W = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PH_W  = (S > 1) ? $clog2(S) : 1;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_n;
    logic [LEN_W-1:0] r_win_cnt;
    logic [PTR_W-1:0] r_wptr;
    logic [PH_W-1:0]  r_phase;
    logic [K*W-1:0]   r_conv_w;
    logic             r_busy, r_done, r_w_ready, r_x_ready, r_w_en, r_din_valid;
    logic             w_busy_nxt, w_done_nxt, w_w_ready_nxt, w_x_ready_nxt, w_w_en_nxt;

    logic             w_start_acc, w_w_acc, w_x_acc;
    logic             w_last_tap, w_last_x, w_full, w_emit;
    logic [LEN_W-1:0] w_n_inc;
    logic [K*W-1:0]   w_win;

    assign w_start_acc = (r_state == IDLE)   && bus.start;
    assign w_w_acc     = (r_state == LOAD_W) && bus.w_valid;
    assign w_x_acc     = (r_state == STREAM) && bus.x_valid;
    assign w_last_tap  = (r_wptr == PTR_W'(K - 1));
    assign w_n_inc     = r_n + LEN_W'(1);
    assign w_last_x    = (w_n_inc == r_len);
    assign w_full      = (w_n_inc >= LEN_W'(K));
    // Stride phase counts down from S-1 between windows once the window is full.
    assign w_emit      = w_x_acc && w_full && (r_phase == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_w_ready   <= 1'b0;
            r_x_ready   <= 1'b0;
            r_w_en      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_w_ready   <= w_w_ready_nxt;
            r_x_ready   <= w_x_ready_nxt;
            r_w_en      <= w_w_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_nxt = LOAD_W;
            LOAD_W:  if (w_w_acc && w_last_tap) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = (r_len == '0) ? DONE : STREAM;
            STREAM:  if (w_x_acc && w_last_x) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the next state so they land in flops alongside it.
    always_comb begin
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_w_ready_nxt = 1'b0;
        w_x_ready_nxt = 1'b0;
        w_w_en_nxt    = 1'b0;
        w_busy_nxt    = (w_state_nxt != IDLE);
        w_done_nxt    = (w_state_nxt == DONE);
        w_w_ready_nxt = (w_state_nxt == LOAD_W);
        w_x_ready_nxt = (w_state_nxt == STREAM);
        w_w_en_nxt    = (w_state_nxt == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_n         <= '0;
            r_win_cnt   <= '0;
            r_wptr      <= '0;
            r_phase     <= '0;
            r_conv_w    <= '0;
            r_din_valid <= 1'b0;
        end else begin
            r_din_valid <= w_emit;
            if (w_start_acc) begin
                r_len     <= bus.seq_len;
                r_n       <= '0;
                r_win_cnt <= '0;
                r_wptr    <= '0;
                r_phase   <= '0;
            end
            if (w_w_acc) begin
                r_conv_w[r_wptr*W +: W] <= bus.w_data;
                r_wptr                  <= w_last_tap ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_x_acc) begin
                r_n <= w_n_inc;
                if (w_full) begin
                    r_phase <= (r_phase == '0) ? PH_W'(S - 1) : r_phase - PH_W'(1);
                end
            end
            if (w_emit) begin
                r_win_cnt <= r_win_cnt + LEN_W'(1);
            end
        end
    end

    conv1d_win_buf #(
        .K (K),
        .W (W)
    ) u_win_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start_acc),
        .i_shift (w_x_acc),
        .i_din   (bus.x_data),
        .o_win   (w_win)
    );

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.w_ready        = r_w_ready;
    assign bus.x_ready        = r_x_ready;
    assign bus.conv_w_en      = r_w_en;
    assign bus.conv_w         = r_conv_w;
    assign bus.conv_din       = w_win;
    assign bus.conv_din_valid = r_din_valid;
    assign bus.win_cnt        = r_win_cnt;

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
// Bench for conv1d_seq_ctrl: stride-1 and stride-2 instances share one stimulus stream.
`timescale 1ns/1ps
module tb_conv1d_seq_ctrl;
    import conv1d_seq_ctrl_pkg::*;

    localparam int unsigned K     = 3;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned W     = WIDTH_DATA;
    localparam int unsigned KW    = K * W;
    localparam int P_IDLE = 0, P_LOAD = 1, P_COMMIT = 2, P_STREAM = 3, P_DONE = 4;

    logic clk = 1'b0;
    logic rst;
    logic             start;
    logic [LEN_W-1:0] seq_len;
    logic             w_valid, x_valid;
    logic [W-1:0]     w_data, x_data;

    always #5 clk = ~clk;

    conv1d_seq_ctrl_if #(.K(K), .LEN_W(LEN_W)) if_s1 ();
    conv1d_seq_ctrl_if #(.K(K), .LEN_W(LEN_W)) if_s2 ();

    conv1d_seq_ctrl #(.K(K), .S(1), .LEN_W(LEN_W)) u_dut_s1 (.clk(clk), .rst(rst), .bus(if_s1));
    conv1d_seq_ctrl #(.K(K), .S(2), .LEN_W(LEN_W)) u_dut_s2 (.clk(clk), .rst(rst), .bus(if_s2));

    assign if_s1.start = start;   assign if_s2.start = start;
    assign if_s1.seq_len = seq_len; assign if_s2.seq_len = seq_len;
    assign if_s1.w_valid = w_valid; assign if_s2.w_valid = w_valid;
    assign if_s1.w_data = w_data; assign if_s2.w_data = w_data;
    assign if_s1.x_valid = x_valid; assign if_s2.x_valid = x_valid;
    assign if_s1.x_data = x_data; assign if_s2.x_data = x_data;

    logic [1:0]       o_busy, o_done, o_wr, o_xr, o_wen, o_dv;
    logic [KW-1:0]    o_cw [2];
    logic [KW-1:0]    o_din [2];
    logic [LEN_W-1:0] o_wc [2];
    assign o_busy = {if_s2.busy, if_s1.busy};
    assign o_done = {if_s2.done, if_s1.done};
    assign o_wr   = {if_s2.w_ready, if_s1.w_ready};
    assign o_xr   = {if_s2.x_ready, if_s1.x_ready};
    assign o_wen  = {if_s2.conv_w_en, if_s1.conv_w_en};
    assign o_dv   = {if_s2.conv_din_valid, if_s1.conv_din_valid};
    assign o_cw[0] = if_s1.conv_w;   assign o_cw[1] = if_s2.conv_w;
    assign o_din[0] = if_s1.conv_din; assign o_din[1] = if_s2.conv_din;
    assign o_wc[0] = if_s1.win_cnt;  assign o_wc[1] = if_s2.win_cnt;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, int d, logic [KW-1:0] act, logic [KW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s s%0d @%0t: got %0h want %0h", name, d + 1, $time, act, exp);
        end
    endfunction

    function automatic logic [KW-1:0] pack3(int oldest, int mid, int newest);
        return {W'(newest), W'(mid), W'(oldest)};
    endfunction

    // Reference model: job phase, weight list and sample history; windows by modulo arithmetic.
    int            m_ph = P_IDLE;
    int            m_len, m_wcnt;
    bit            m_live = 1'b0;
    bit            m_zero;
    logic [W-1:0]  m_w [K];
    logic [W-1:0]  m_hist [$];
    int            m_wc [2];
    logic          e_dv [2];
    logic [KW-1:0] e_din [2];

    always @(posedge clk) begin : model
        int n;
        e_dv[0] = 1'b0;
        e_dv[1] = 1'b0;
        if (rst) begin
            m_live = 1'b1;
            m_ph   = P_IDLE;
            for (int k = 0; k < K; k++) m_w[k] = '0;
            m_hist.delete();
            m_wc[0] = 0; m_wc[1] = 0;
            m_zero = 1'b1;
        end else begin
            case (m_ph)
                P_IDLE: if (start) begin
                    m_len  = int'(seq_len);
                    m_wcnt = 0;
                    m_hist.delete();
                    m_wc[0] = 0; m_wc[1] = 0;
                    m_zero = 1'b1;
                    m_ph   = P_LOAD;
                end
                P_LOAD: if (w_valid) begin
                    m_w[m_wcnt] = w_data;
                    m_wcnt++;
                    if (m_wcnt == K) m_ph = P_COMMIT;
                end
                P_COMMIT: m_ph = (m_len == 0) ? P_DONE : P_STREAM;
                P_STREAM: if (x_valid) begin
                    m_hist.push_back(x_data);
                    m_zero = 1'b0;
                    n = m_hist.size();
                    for (int d = 0; d < 2; d++) begin
                        if (n >= K && ((n - K) % (d + 1)) == 0) begin
                            e_dv[d] = 1'b1;
                            for (int j = 0; j < K; j++) e_din[d][j*W +: W] = m_hist[n - K + j];
                            m_wc[d]++;
                        end
                    end
                    if (n == m_len) m_ph = P_DONE;
                end
                default: m_ph = P_IDLE;
            endcase
        end
    end

    logic [KW-1:0] obs_w0 [$];
    logic [KW-1:0] obs_w1 [$];
    int            obs_done, obs_wen;

    always @(negedge clk) begin : compare
        logic [KW-1:0] ew;
        if (m_live) begin
            for (int k = 0; k < K; k++) ew[k*W +: W] = m_w[k];
            for (int d = 0; d < 2; d++) begin
                chk("busy",    d, KW'(o_busy[d]), KW'(m_ph != P_IDLE));
                chk("done",    d, KW'(o_done[d]), KW'(m_ph == P_DONE));
                chk("w_ready", d, KW'(o_wr[d]),   KW'(m_ph == P_LOAD));
                chk("x_ready", d, KW'(o_xr[d]),   KW'(m_ph == P_STREAM));
                chk("w_en",    d, KW'(o_wen[d]),  KW'(m_ph == P_COMMIT));
                chk("conv_w",  d, o_cw[d], ew);
                chk("din_vld", d, KW'(o_dv[d]),   KW'(e_dv[d]));
                chk("win_cnt", d, KW'(o_wc[d]),   KW'(m_wc[d]));
                if (e_dv[d])    chk("conv_din", d, o_din[d], e_din[d]);
                else if (m_zero) chk("din_clr", d, o_din[d], '0);
            end
            if (o_dv[0]) obs_w0.push_back(o_din[0]);
            if (o_dv[1]) obs_w1.push_back(o_din[1]);
            if (o_done[0]) obs_done++;
            if (o_wen[0]) obs_wen++;
        end
    end

    task automatic clear_obs();
        obs_w0.delete(); obs_w1.delete(); obs_done = 0; obs_wen = 0;
    endtask

    task automatic start_job(input int len);
        start = 1'b1; seq_len = LEN_W'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_w(input int d, input int gap);
        w_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        w_valid = 1'b1; w_data = W'(d);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (if_s1.w_ready) begin @(posedge clk); #1; w_valid = 1'b0; return; end
            @(posedge clk); #1;
        end
        n_checks++; n_errors++;
        $display("FAIL w_handshake timeout @%0t", $time);
        w_valid = 1'b0;
    endtask

    task automatic push_x(input int d, input int gap);
        x_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        x_valid = 1'b1; x_data = W'(d);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (if_s1.x_ready) begin @(posedge clk); #1; x_valid = 1'b0; return; end
            @(posedge clk); #1;
        end
        n_checks++; n_errors++;
        $display("FAIL x_handshake timeout @%0t", $time);
        x_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!o_busy[0]) begin @(posedge clk); #1; return; end
        end
        n_checks++; n_errors++;
        $display("FAIL idle timeout @%0t", $time);
    endtask

    task automatic run_job(input int len, input int w0, input int w1, input int w2,
                           input int x0, input int maxgap);
        clear_obs();
        start_job(len);
        push_w(w0, $urandom_range(0, maxgap));
        push_w(w1, $urandom_range(0, maxgap));
        push_w(w2, $urandom_range(0, maxgap));
        for (int i = 0; i < len; i++) push_x(x0 + i, $urandom_range(0, maxgap));
        wait_idle();
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, d, KW'(o_busy[d]), '0);
            chk({tag, "_done"}, d, KW'(o_done[d]), '0);
            chk({tag, "_wen"},  d, KW'(o_wen[d]),  '0);
            chk({tag, "_dv"},   d, KW'(o_dv[d]),   '0);
            chk({tag, "_wc"},   d, KW'(o_wc[d]),   '0);
            chk({tag, "_cw"},   d, o_cw[d],        '0);
            chk({tag, "_din"},  d, o_din[d],       '0);
        end
    endtask

    task automatic check_job_a();
        chk("a_conv_w", 0, o_cw[0], pack3(1, 2, 3));
        chk("a_wen_n",  0, KW'(obs_wen), KW'(1));
        chk("a_done_n", 0, KW'(obs_done), KW'(1));
        chk("a_nwin",   0, KW'(obs_w0.size()), KW'(3));
        chk("a_win0",   0, obs_w0[0], pack3(10, 11, 12));
        chk("a_win1",   0, obs_w0[1], pack3(11, 12, 13));
        chk("a_win2",   0, obs_w0[2], pack3(12, 13, 14));
        chk("a_cnt",    0, KW'(o_wc[0]), KW'(3));
        chk("a_nwin",   1, KW'(obs_w1.size()), KW'(2));
        chk("a_win0",   1, obs_w1[0], pack3(10, 11, 12));
        chk("a_win1",   1, obs_w1[1], pack3(12, 13, 14));
        chk("a_cnt",    1, KW'(o_wc[1]), KW'(2));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1; start = 1'b0; seq_len = '0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_zero("rst");
        @(posedge clk); #1;

        run_job(5, 1, 2, 3, 10, 0);
        check_job_a();

        run_job(7, 4, 5, 6, 1, 0);
        chk("b_nwin", 1, KW'(obs_w1.size()), KW'(3));
        chk("b_win0", 1, obs_w1[0], pack3(1, 2, 3));
        chk("b_win1", 1, obs_w1[1], pack3(3, 4, 5));
        chk("b_win2", 1, obs_w1[2], pack3(5, 6, 7));
        chk("b_cnt",  1, KW'(o_wc[1]), KW'(3));
        chk("b_cnt",  0, KW'(o_wc[0]), KW'(5));

        // Short job: fewer samples than taps.
        clear_obs();
        start_job(2);
        push_w(7, 0); push_w(8, 0); push_w(9, 0);
        push_x(40, 0); push_x(41, 1);
        @(negedge clk);
        chk("c_done_at", 0, KW'(o_done[0]), KW'(1));
        chk("c_xr_low",  0, KW'(o_xr[0]),   KW'(0));
        wait_idle();
        chk("c_nwin", 0, KW'(obs_w0.size()), KW'(0));
        chk("c_cnt",  0, KW'(o_wc[0]), KW'(0));

        // Empty job: commit then done.
        clear_obs();
        start_job(0);
        push_w(11, 0); push_w(12, 0); push_w(13, 0);
        @(negedge clk);
        chk("z_wen", 0, KW'(o_wen[0]), KW'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_done", 0, KW'(o_done[0]), KW'(1));
        wait_idle();
        chk("z_conv_w", 0, o_cw[0], pack3(11, 12, 13));
        chk("z_done_n", 0, KW'(obs_done), KW'(1));

        // Job A again with random valid gaps.
        run_job(5, 1, 2, 3, 10, 3);
        check_job_a();

        // Reset after the second window.
        clear_obs();
        start_job(5);
        push_w(1, 0); push_w(2, 0); push_w(3, 0);
        for (int i = 0; i < 4; i++) push_x(10 + i, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("mid_rst");
        chk("r_nwin_pre", 0, KW'(obs_w0.size()), KW'(2));
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(3, 7, 8, 9, 20, 1);
        chk("r_nwin", 0, KW'(obs_w0.size()), KW'(1));
        chk("r_win0", 0, obs_w0[0], pack3(20, 21, 22));
        chk("r_cnt",  0, KW'(o_wc[0]), KW'(1));

        // Stray start and seq_len change mid-stream.
        clear_obs();
        start_job(4);
        push_w(1, 0); push_w(1, 0); push_w(1, 0);
        push_x(30, 0); push_x(31, 0);
        start = 1'b1; seq_len = LEN_W'(9);
        @(posedge clk); #1;
        start = 1'b0; seq_len = LEN_W'(2);
        push_x(32, 0); push_x(33, 0);
        wait_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("s_idle",   0, KW'(o_busy[0]), KW'(0));
        chk("s_done_n", 0, KW'(obs_done), KW'(1));
        chk("s_nwin",   0, KW'(obs_w0.size()), KW'(2));
        chk("s_win1",   0, obs_w0[1], pack3(31, 32, 33));
        chk("s_cnt",    0, KW'(o_wc[0]), KW'(2));
        chk("s_cnt",    1, KW'(o_wc[1]), KW'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
